// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - valid/ready pipeline register chain with bubble collapse
// Stage 0 faces the input, stage DEPTH-1 drives out_*; DEPTH=0 is a pass-through.
module pipe_reg_chain #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  localparam int CNT_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic en;
  assign en = CE & ~clr;

  if (DEPTH == 0) begin : g_pass
    logic [CNT_W-1:0] cnt_q;

    assign in_ready  = out_ready & en;
    assign out_valid = in_valid & en;
    assign out_data  = in_data;
    assign count     = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= '0;
    end
  end else begin : g_chain
    logic [DEPTH-1:0] v_q, v_d, take, src_v;
    logic [WIDTH-1:0] d_q   [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer, out_xfer;

    // A stage can load when empty or when its occupant moves on this cycle;
    // the ready chain ripples back from out_ready through every stage.
    always_comb begin
      logic carry;
      carry = out_ready;
      take  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        take[i] = en & (~v_q[i] | carry);
        carry   = take[i];
      end
    end

    assign src_v = (v_q << 1) | DEPTH'(in_valid);

    always_comb begin
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) src_d[i] = d_q[i-1];
    end

    always_comb begin
      v_d = v_q;
      if (clr) v_d = '0;
      else begin
        for (int i = 0; i < DEPTH; i++)
          if (take[i]) v_d[i] = src_v[i];
      end
    end

    assign in_xfer  = in_valid & take[0];
    assign out_xfer = out_valid & out_ready;
    assign cnt_d    = clr ? '0 : cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q   <= '0;
        cnt_q <= '0;
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      end else begin
        v_q   <= v_d;
        cnt_q <= cnt_d;
        // Data only moves with a valid item, so bubbles never overwrite it.
        for (int i = 0; i < DEPTH; i++)
          if (take[i] && src_v[i]) d_q[i] <= src_d[i];
      end
    end

    assign in_ready  = take[0];
    assign out_valid = v_q[DEPTH-1] & en;
    assign out_data  = d_q[DEPTH-1];
    assign count     = cnt_q;
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed checks of pipe_reg_chain at DEPTH 3, 4 and 0
module tb_pipe_reg_chain;
  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DEPTH=3
  logic a_rst, a_ce, a_clr, a_iv, a_ir, a_ov, a_or;
  logic [W-1:0] a_id, a_od;
  logic [1:0]   a_cnt;
  // DEPTH=4
  logic b_rst, b_ce, b_clr, b_iv, b_ir, b_ov, b_or;
  logic [W-1:0] b_id, b_od;
  logic [2:0]   b_cnt;
  // DEPTH=0
  logic c_rst, c_ce, c_clr, c_iv, c_ir, c_ov, c_or;
  logic [W-1:0] c_id, c_od;
  logic [0:0]   c_cnt;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(3)) u_a (
    .clk(clk), .rst(a_rst), .CE(a_ce), .clr(a_clr),
    .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .count(a_cnt));

  pipe_reg_chain #(.WIDTH(W), .DEPTH(4)) u_b (
    .clk(clk), .rst(b_rst), .CE(b_ce), .clr(b_clr),
    .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .count(b_cnt));

  pipe_reg_chain #(.WIDTH(W), .DEPTH(0)) u_c (
    .clk(clk), .rst(c_rst), .CE(c_ce), .clr(c_clr),
    .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_ready(c_or), .count(c_cnt));

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    a_rst = 0; a_ce = 1; a_clr = 0; a_iv = 0; a_id = '0; a_or = 0;
    b_rst = 0; b_ce = 1; b_clr = 0; b_iv = 0; b_id = '0; b_or = 0;
    c_rst = 0; c_ce = 1; c_clr = 0; c_iv = 0; c_id = '0; c_or = 0;
    #12;
    check("rst_out_valid", {31'd0, a_ov}, 32'd0);
    check("rst_out_data", {14'd0, a_od}, 32'd0);
    check("rst_count", {30'd0, a_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, a_ir}, 32'd1);
    step();
    a_rst = 1; b_rst = 1; c_rst = 1;

    // 1: back-to-back stream, first item visible 3 cycles after accept
    a_or = 1;
    for (int c = 0; c < 9; c++) begin
      a_iv = (c < 5);
      a_id = W'(c + 1);
      #1;
      if (c < 5) check("t1_in_ready", {31'd0, a_ir}, 32'd1);
      check("t1_out_valid", {31'd0, a_ov}, (c >= 3 && c <= 7) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 7) check("t1_out_data", {14'd0, a_od}, 32'(c - 2));
      if (c >= 3 && c <= 5) check("t1_count", {30'd0, a_cnt}, 32'd3);
      step();
    end
    check("t1_count_end", {30'd0, a_cnt}, 32'd0);

    // 2: stalled output fills the chain, then release preserves order
    a_or = 0; a_iv = 1;
    for (int c = 0; c < 3; c++) begin
      a_id = W'(c + 1);
      #1;
      check("t2_in_ready_fill", {31'd0, a_ir}, 32'd1);
      step();
    end
    a_id = W'(4);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t2_in_ready_full", {31'd0, a_ir}, 32'd0);
      check("t2_count_full", {30'd0, a_cnt}, 32'd3);
      check("t2_head", {14'd0, a_od}, 32'd1);
      step();
    end
    a_or = 1;
    #1;
    check("t2_in_ready_release", {31'd0, a_ir}, 32'd1);
    check("t2_out_1", {14'd0, a_od}, 32'd1);
    step();
    for (int c = 0; c < 5; c++) begin
      a_iv = (c == 0);
      a_id = W'(5);
      #1;
      check("t2_out_valid", {31'd0, a_ov}, (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) check("t2_out_order", {14'd0, a_od}, 32'(c + 2));
      step();
    end
    check("t2_count_end", {30'd0, a_cnt}, 32'd0);

    // 6: CE=0 freezes a full chain with out_ready high
    a_or = 0; a_iv = 1;
    for (int c = 0; c < 3; c++) begin
      a_id = W'(32'h10 + c);
      step();
    end
    a_or = 1; a_ce = 0; a_id = W'(32'h99);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t6_ce0_out_valid", {31'd0, a_ov}, 32'd0);
      check("t6_ce0_in_ready", {31'd0, a_ir}, 32'd0);
      check("t6_ce0_count", {30'd0, a_cnt}, 32'd3);
      step();
    end
    a_ce = 1; a_iv = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t6_drain_valid", {31'd0, a_ov}, (c < 3) ? 32'd1 : 32'd0);
      if (c < 3) check("t6_drain_data", {14'd0, a_od}, 32'h10 + 32'(c));
      step();
    end

    // 5: asynchronous reset of a full chain between edges
    a_or = 0; a_iv = 1;
    for (int c = 0; c < 3; c++) begin
      a_id = W'(32'h20 + c);
      step();
    end
    a_iv = 0;
    #1;
    check("t5_pre_count", {30'd0, a_cnt}, 32'd3);
    #2;
    a_rst = 0;
    #1;
    check("t5_rst_out_valid", {31'd0, a_ov}, 32'd0);
    check("t5_rst_out_data", {14'd0, a_od}, 32'd0);
    check("t5_rst_count", {30'd0, a_cnt}, 32'd0);
    step();
    a_rst = 1; a_or = 1;
    #1;
    check("t5_rel_in_ready", {31'd0, a_ir}, 32'd1);
    step();
    check("t5_no_stale", {31'd0, a_ov}, 32'd0);

    // 3: bubble collapse in DEPTH=4 with output stalled
    b_or = 0;
    b_iv = 1; b_id = W'(32'hA); step();
    b_iv = 0; step(); step();
    b_iv = 1; b_id = W'(32'hB); step();
    b_iv = 0; step(); step(); step();
    #1;
    check("t3_count", {29'd0, b_cnt}, 32'd2);
    check("t3_in_ready", {31'd0, b_ir}, 32'd1);
    check("t3_head", {14'd0, b_od}, 32'hA);
    b_or = 1;
    step();
    check("t3_adjacent_valid", {31'd0, b_ov}, 32'd1);
    check("t3_adjacent_data", {14'd0, b_od}, 32'hB);
    step();
    check("t3_empty", {31'd0, b_ov}, 32'd0);

    // 4: clr discards in-flight items and the offered one
    b_or = 0; b_iv = 1;
    b_id = W'(32'h31); step();
    b_id = W'(32'h32); step();
    check("t4_pre_count", {29'd0, b_cnt}, 32'd2);
    b_clr = 1; b_id = W'(32'h33);
    #1;
    check("t4_clr_in_ready", {31'd0, b_ir}, 32'd0);
    check("t4_clr_out_valid", {31'd0, b_ov}, 32'd0);
    step();
    b_clr = 0; b_iv = 0;
    #1;
    check("t4_post_count", {29'd0, b_cnt}, 32'd0);
    b_or = 1;
    for (int c = 0; c < 6; c++) begin
      check("t4_never_out", {31'd0, b_ov}, 32'd0);
      step();
    end

    // DEPTH=0 pass-through, stream and CE freeze
    c_or = 1; c_iv = 1;
    for (int c = 0; c < 5; c++) begin
      c_id = W'(c + 1);
      #1;
      check("p1_out_valid", {31'd0, c_ov}, 32'd1);
      check("p1_out_data", {14'd0, c_od}, 32'(c + 1));
      check("p1_in_ready", {31'd0, c_ir}, 32'd1);
      check("p1_count", {31'd0, c_cnt}, 32'd0);
      step();
    end
    c_or = 0;
    #1;
    check("p1_backpressure", {31'd0, c_ir}, 32'd0);
    c_or = 1; c_ce = 0; c_id = W'(32'h3FFFF);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("p6_ce0_out_valid", {31'd0, c_ov}, 32'd0);
      check("p6_ce0_in_ready", {31'd0, c_ir}, 32'd0);
      step();
    end
    c_ce = 1;
    #1;
    check("p6_resume_valid", {31'd0, c_ov}, 32'd1);
    check("p6_resume_data", {14'd0, c_od}, 32'h3FFFF);
    c_clr = 1;
    #1;
    check("p6_clr_out_valid", {31'd0, c_ov}, 32'd0);
    check("p6_clr_in_ready", {31'd0, c_ir}, 32'd0);
    c_clr = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
